mppc_pulse_emulator: RTL and testbench



---
 rtl/mppc_emu_pkg.sv | 27 ++
 rtl/mppc_pulse_emulator_lfsr16.sv | 34 +++
 rtl/mppc_pulse_emulator.sv | 185 ++++++++++++++++++
 tb/tb_mppc_pulse_emulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mppc_emu_pkg.sv
// ---------------------------------------------------------------------------
// mppc_emu_pkg
// Shared definitions for the MPPC discriminator-pulse emulator:
//   - FSM state encoding (IDLE, PULSE, GAP, DONE)
//   - LFSR seed and Galois tap mask for the optional random-gap mode
//   - width of the gap down-counter
// ---------------------------------------------------------------------------
package mppc_emu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } emu_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int GAP_CNT_W = 24;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/mppc_pulse_emulator_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR used to randomise the inter-pulse gap.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, reloads the seed
//   advance  in   step the register by one position
//   value    out  current LFSR contents
// ---------------------------------------------------------------------------
module lfsr16
  import mppc_emu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/mppc_pulse_emulator.sv
// ---------------------------------------------------------------------------
// mppc_pulse_emulator
// Synthetic DISC-pulse source for self-test of the MPPC dark counter.
// Emits bursts of fixed-width pulses with programmable spacing and length.
//
// Ports:
//   clk         in   100 MHz clock
//   rst         in   synchronous active-high reset
//   start       in   asynchronous button/switch; a rising edge starts a burst
//   stop        in   synchronous abort request (honoured at pulse end / in gap)
//   period_sel  in   gap = BASE_GAP << period_sel
//   n_pulses    in   burst length, 0 = free-running until stop
//   pulse_out   out  registered emulated DISC pulse
//   busy        out  high while a burst is in progress (state != IDLE)
//   done        out  one-cycle strobe at burst completion
//   sent_count  out  pulses emitted in the current or last burst
//
// Build option: define MPPC_EMU_RANDOM_GAP_EN to replace the fixed gap by
// MIN_GAP + (lfsr & mask), giving Poisson-like spacing.
// ---------------------------------------------------------------------------
module mppc_pulse_emulator
  import mppc_emu_pkg::*;
#(
  parameter int PULSE_WIDTH = 4,
  parameter int BASE_GAP    = 16,
  parameter int MIN_GAP     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       period_sel,
  input  logic [CNT_W-1:0] n_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int PW_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [PW_W-1:0]      PW_LAST    = PW_W'(PULSE_WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] BASE_GAP_V = GAP_CNT_W'(BASE_GAP);

  // Start conditioning: s1/s2 synchronise, s3/s4 give the rising edge one
  // flop later so start_pulse lands three edges after the first sample.
  logic s1_q, s2_q, s3_q, s4_q, start_pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      s4_q          <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      s1_q          <= start;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      s4_q          <= s3_q;
      start_pulse_q <= s3_q & ~s4_q;
    end
  end

  emu_state_e             state_q, state_d;
  logic [PW_W-1:0]        wcnt_q, wcnt_d;
  logic [GAP_CNT_W-1:0]   gcnt_q, gcnt_d;
  logic [GAP_CNT_W-1:0]   gap_len_q, gap_len_d;
  logic [CNT_W-1:0]       npul_q, npul_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic [CNT_W-1:0]       sent_inc;
  logic                   stop_pend_q, stop_pend_d;
  logic                   pulse_q, done_q;
  logic [GAP_CNT_W-1:0]   gap_entry;

`ifdef MPPC_EMU_RANDOM_GAP_EN
  logic [15:0]          lfsr_val;
  logic                 lfsr_adv;
  logic [GAP_CNT_W-1:0] gap_mask;

  // gap_len_q holds BASE_GAP << period_sel, so minus one is the mask;
  // only its low 16 bits can select LFSR bits.
  assign gap_mask  = gap_len_q - 1'b1;
  assign gap_entry = GAP_CNT_W'(MIN_GAP) +
                     {{(GAP_CNT_W-16){1'b0}}, lfsr_val & gap_mask[15:0]};
  assign lfsr_adv  = (state_q == PULSE) && (state_d == GAP);

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );
`else
  assign gap_entry = gap_len_q;
`endif

  assign sent_inc = sent_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    gap_len_d   = gap_len_q;
    npul_d      = npul_q;
    sent_d      = sent_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        if (start_pulse_q) begin
          gap_len_d   = BASE_GAP_V << period_sel;
          npul_d      = n_pulses;
          sent_d      = '0;
          wcnt_d      = '0;
          stop_pend_d = 1'b0;
          state_d     = PULSE;
        end
      end
      PULSE: begin
        // A stop seen anywhere in the pulse is remembered and acted on only
        // once the full width has been emitted.
        if (stop) stop_pend_d = 1'b1;
        if (wcnt_q == PW_LAST) begin
          wcnt_d      = '0;
          sent_d      = sent_inc;
          stop_pend_d = 1'b0;
          if ((npul_q != '0) && (sent_inc == npul_q)) begin
            state_d = DONE;
          end else if (stop || stop_pend_q) begin
            state_d = DONE;
          end else begin
            gcnt_d  = gap_entry - 1'b1;
            state_d = GAP;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = DONE;
        end else if (gcnt_q == '0) begin
          wcnt_d  = '0;
          state_d = PULSE;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      gcnt_q      <= '0;
      gap_len_q   <= '0;
      npul_q      <= '0;
      sent_q      <= '0;
      stop_pend_q <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      gcnt_q      <= gcnt_d;
      gap_len_q   <= gap_len_d;
      npul_q      <= npul_d;
      sent_q      <= sent_d;
      stop_pend_q <= stop_pend_d;
      pulse_q     <= (state_d == PULSE);
      done_q      <= (state_d == DONE);
    end
  end

  assign pulse_out  = pulse_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign sent_count = sent_q;

endmodule

// File: tb/tb_mppc_pulse_emulator.sv
module tb_mppc_pulse_emulator;

  localparam int PW    = 4;
  localparam int BGAP  = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [3:0]       period_sel = 4'd0;
  logic [CNT_W-1:0] n_pulses = '0;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mppc_pulse_emulator #(
    .PULSE_WIDTH (PW),
    .BASE_GAP    (BGAP),
    .MIN_GAP     (2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .period_sel (period_sel),
    .n_pulses   (n_pulses),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag, input int obs);
    int e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  // Edges until pulse_out reaches lvl; -1 if the budget expires.
  task automatic wait_level(input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pulse_out !== lvl && n < budget);
    if (pulse_out !== lvl) n = -1;
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fire_start();
    @(posedge clk); #1;
    start = 1'b1;
  endtask

  task automatic plan_burst(input int np, input int gap);
    push(4);
    for (int i = 0; i < np; i++) begin
      push(PW);
      if (i < np - 1) push(gap);
    end
    push(1);   // done strobe right after last fall
    push(1);   // busy still high in DONE cycle
    push(np);  // sent_count
    push(0);   // busy after return to IDLE
    push(0);   // done gone
  endtask

  // chg_psel >= 0: change period_sel after the first pulse has started.
  task automatic observe_burst(input string tag, input int np, input int chg_psel);
    int n;
    wait_level(1'b1, 40, n);
    compare({tag, "_latency"}, (n < 0) ? -1 : n - 1);
    start = 1'b0;
    if (chg_psel >= 0) period_sel = 4'(chg_psel);
    for (int i = 0; i < np; i++) begin
      wait_level(1'b0, 40, n);
      compare({tag, "_high"}, n);
      if (i < np - 1) begin
        wait_level(1'b1, 2000, n);
        compare({tag, "_gap"}, n);
      end
    end
    compare({tag, "_done"}, int'(done));
    compare({tag, "_busy_in_done"}, int'(busy));
    step(1);
    compare({tag, "_sent"}, int'(sent_count));
    compare({tag, "_busy_after"}, int'(busy));
    compare({tag, "_done_after"}, int'(done));
  endtask

  // Count rising edges on pulse_out over a window.
  task automatic count_rises(input int cycles, output int rises);
    logic prev;
    rises = 0;
    prev  = pulse_out;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (pulse_out && !prev) rises++;
      prev = pulse_out;
    end
  endtask

  initial begin
    int n;
    int r;

    // Reset state
    step(3);
    push(0); push(0); push(0); push(0);
    compare("rst_pulse_out", int'(pulse_out));
    compare("rst_busy", int'(busy));
    compare("rst_done", int'(done));
    compare("rst_sent", int'(sent_count));
    rst = 1'b0;
    step(3);

    // Defaults: period_sel=0, 3 pulses, 4 high / 16 low
    period_sel = 4'd0; n_pulses = 16'd3;
    plan_burst(3, 16);
    fire_start();
    observe_burst("b3", 3, -1);
    step(5);

    // period_sel=2 -> 64-cycle gap; mid-burst change to 0 must not matter
    period_sel = 4'd2; n_pulses = 16'd2;
    plan_burst(2, 64);
    fire_start();
    observe_burst("ps2", 2, 0);
    step(5);

    // stop held in IDLE: start accepted, burst ends after the first pulse
    period_sel = 4'd0; n_pulses = 16'd3; stop = 1'b1;
    step(3);
    plan_burst(1, 16);
    fire_start();
    observe_burst("idlestop", 1, -1);
    stop = 1'b0;
    step(5);

    // Free-run, stop in 2nd cycle of the 5th pulse
    n_pulses = 16'd0;
    fire_start();
    push(4);
    wait_level(1'b1, 40, n);
    compare("fr_latency", (n < 0) ? -1 : n - 1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(PW); push(16);
      wait_level(1'b0, 40, n); compare("fr_high", n);
      wait_level(1'b1, 40, n); compare("fr_gap", n);
    end
    step(1);
    stop = 1'b1;
    push(PW - 1); push(1); push(5); push(0);
    wait_level(1'b0, 40, n);
    compare("fr_stop_rest_high", n);
    compare("fr_done", int'(done));
    compare("fr_sent", int'(sent_count));
    stop = 1'b0;
    step(1);
    compare("fr_busy_after", int'(busy));
    step(5);

    // Reset during the GAP after the 2nd pulse
    n_pulses = 16'd3;
    fire_start();
    wait_level(1'b1, 40, n);
    start = 1'b0;
    wait_level(1'b0, 40, n);
    wait_level(1'b1, 40, n);
    wait_level(1'b0, 40, n);
    step(3);
    push(1); push(2);
    compare("pre_rst_busy", int'(busy));
    compare("pre_rst_sent", int'(sent_count));
    rst = 1'b1;
    start = 1'b1;
    push(0); push(0); push(0);
    step(1);
    compare("midrst_pulse_out", int'(pulse_out));
    compare("midrst_busy", int'(busy));
    compare("midrst_sent", int'(sent_count));
    step(3);
    start = 1'b0;
    step(1);
    rst = 1'b0;
    push(0); push(0);
    count_rises(60, r);
    compare("post_rst_rises", r);
    compare("post_rst_busy", int'(busy));

    // Second start edge during a burst is ignored
    n_pulses = 16'd3;
    plan_burst(3, 16);
    fire_start();
    wait_level(1'b1, 40, n);
    compare("dbl_latency", (n < 0) ? -1 : n - 1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start = 1'b1;
      wait_level(1'b0, 40, n); compare("dbl_high", n);
      if (i < 2) begin
        wait_level(1'b1, 40, n); compare("dbl_gap", n);
      end
    end
    compare("dbl_done", int'(done));
    compare("dbl_busy_in_done", int'(busy));
    step(1);
    compare("dbl_sent", int'(sent_count));
    compare("dbl_busy_after", int'(busy));
    compare("dbl_done_after", int'(done));
    start = 1'b0;
    push(0); push(3);
    count_rises(60, r);
    compare("dbl_no_restart", r);
    compare("dbl_sent_hold", int'(sent_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
